// File: rtl/bus_master_arbiter_if.sv
// Request/grant bundle shared by the bus masters and the arbiter, plus arbiter status.
interface bus_master_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned CNT_WIDTH   = 32
);
    localparam int unsigned IdW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req;
    logic                   done;
    logic [NUM_MASTERS-1:0] grant;
    logic                   grant_valid;
    logic [IdW-1:0]         grant_id;
    logic [NUM_MASTERS-1:0] starve_flag;
    logic [CNT_WIDTH-1:0]   grant_count;
    logic [CNT_WIDTH-1:0]   conflict_count;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_id, starve_flag, grant_count, conflict_count
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_id, starve_flag, grant_count, conflict_count
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin bus arbiter with burst locality and starvation escape; grant held until
// done or abort.
module bus_master_arbiter #(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned BURST_LIMIT  = 4,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input logic                 clk,
    input logic                 rst,
    bus_master_arbiter_if.slave bus
);
    localparam int unsigned IdW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned BW  = $clog2(BURST_LIMIT + 1);
    localparam int unsigned WW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BurstMax  = BW'(BURST_LIMIT);
    localparam logic [WW-1:0] StarveMax = WW'(STARVE_LIMIT);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] starve_q;
    logic [IdW-1:0]         grant_id_q;
    logic [IdW-1:0]         last_q;
    logic [BW-1:0]          burst_q;
    logic [WW-1:0]          wait_q [NUM_MASTERS];
    logic [CNT_WIDTH-1:0]   grant_cnt_q;
    logic [CNT_WIDTH-1:0]   conflict_cnt_q;

    logic [WW-1:0]          wait_d [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] win_oh;
    logic [NUM_MASTERS-1:0] last_oh;
    logic [IdW-1:0]         winner;
    logic [IdW-1:0]         cand;
    logic                   any_req;
    logic                   multi_req;
    logic                   other_req;
    logic                   starve_hit;
    logic                   burst_keep;
    logic                   found;

    always_comb begin
        winner     = '0;
        cand       = '0;
        starve_hit = 1'b0;
        found      = 1'b0;
        last_oh    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            last_oh[i] = (last_q == IdW'(i));
        end
        any_req    = |bus.req;
        multi_req  = |(bus.req & (bus.req - 1'b1));
        other_req  = |(bus.req & ~last_oh);
        burst_keep = bus.req[last_q] && (burst_q != '0) && ((burst_q < BurstMax) || !other_req);

        // Descending scan so the lowest starving requester wins.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (starve_q[i] && bus.req[i]) begin
                winner     = IdW'(i);
                starve_hit = 1'b1;
            end
        end
        if (!starve_hit) begin
            if (burst_keep) begin
                winner = last_q;
            end else begin
                for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                    cand = IdW'((32'(last_q) + k) % NUM_MASTERS);
                    if (!found && bus.req[cand]) begin
                        winner = cand;
                        found  = 1'b1;
                    end
                end
            end
        end

        win_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            win_oh[i] = (winner == IdW'(i));
        end
    end

    // Waiting time per master; the master being granted this edge restarts from zero.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!bus.req[i]) begin
                wait_d[i] = '0;
            end else if (state_q == StIdle && win_oh[i]) begin
                wait_d[i] = '0;
            end else if (!grant_q[i] && wait_q[i] < StarveMax) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            grant_id_q     <= '0;
            last_q         <= IdW'(NUM_MASTERS - 1);
            burst_q        <= '0;
            starve_q       <= '0;
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                wait_q[i]   <= wait_d[i];
                starve_q[i] <= (wait_d[i] >= StarveMax);
            end
            case (state_q)
                StIdle: begin
                    if (multi_req) begin
                        conflict_cnt_q <= conflict_cnt_q + 1'b1;
                    end
                    if (any_req) begin
                        state_q     <= StBusy;
                        grant_q     <= win_oh;
                        grant_id_q  <= winner;
                        last_q      <= winner;
                        grant_cnt_q <= grant_cnt_q + 1'b1;
                        if (winner == last_q) begin
                            burst_q <= (burst_q == BurstMax) ? burst_q : burst_q + 1'b1;
                        end else begin
                            burst_q <= BW'(1);
                        end
                    end
                end
                StBusy: begin
                    if (bus.done || !bus.req[grant_id_q]) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant          = grant_q;
    assign bus.grant_valid    = |grant_q;
    assign bus.grant_id       = grant_id_q;
    assign bus.starve_flag    = starve_q;
    assign bus.grant_count    = grant_cnt_q;
    assign bus.conflict_count = conflict_cnt_q;
endmodule
